// File: rtl/piso_serializer_32_bit_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_32_bit_if
// Description : Producer-side handshake and serial-side outputs of the
//               32-bit PISO serializer, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_32_bit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  Enable_In;
   logic [DATA_WIDTH-1:0] Parallel_Data_In;
   logic                  Data_Valid_In;
   logic                  Data_Ready_Out;
   logic                  Serial_Data_Out;
   logic                  Shift_Data_Signal_Out;
   logic                  Word_Done_Out;
   logic                  Busy_Out;

   // Serializer side: consumes the word, drives the serial stream
   modport slave (
      input  Enable_In,
      input  Parallel_Data_In,
      input  Data_Valid_In,
      output Data_Ready_Out,
      output Serial_Data_Out,
      output Shift_Data_Signal_Out,
      output Word_Done_Out,
      output Busy_Out
   );

   // Producer / observer side
   modport master (
      output Enable_In,
      output Parallel_Data_In,
      output Data_Valid_In,
      input  Data_Ready_Out,
      input  Serial_Data_Out,
      input  Shift_Data_Signal_Out,
      input  Word_Done_Out,
      input  Busy_Out
   );
endinterface
`default_nettype wire

// File: rtl/piso_serializer_32_bit.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer_32_bit
// Description : Accepts a parallel word over valid/ready and shifts it out
//               MSB first with a per-bit strobe for a downstream SIPO.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer_32_bit #(
   parameter int DATA_WIDTH = 32,
   parameter int BIT_PERIOD = 1,
   parameter int GAP_CYCLES = 0
) (
   input  logic                     Clk_In,
   input  logic                     Reset_In,
   piso_serializer_32_bit_if.slave  bus
);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int PW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [BW-1:0] BIT_FIRST = BW'(DATA_WIDTH - 1);
   localparam logic [PW-1:0] PER_LAST  = PW'(BIT_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [PW-1:0]         period_cnt_q, period_cnt_d;
   logic [GW-1:0]         gap_cnt_q, gap_cnt_d;

   logic strobe;
   logic last_bit;
   logic ready;
   logic accept;

   // Strobe on the last enabled clock of each bit; ready is suppressed during reset
   always_comb begin
      strobe   = (state_q == S_SHIFT) && bus.Enable_In && (period_cnt_q == PER_LAST);
      last_bit = strobe && (bit_cnt_q == '0);
      ready    = !Reset_In && bus.Enable_In &&
                 ((state_q == S_IDLE) || (last_bit && (GAP_CYCLES == 0)));
      accept   = ready && bus.Data_Valid_In;
   end

   // Next-state logic; everything holds while Enable_In is low
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      period_cnt_d = period_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      if (bus.Enable_In) begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_d      = S_SHIFT;
                  shreg_d      = bus.Parallel_Data_In;
                  bit_cnt_d    = BIT_FIRST;
                  period_cnt_d = '0;
               end
            end
            S_SHIFT: begin
               if (!strobe) begin
                  period_cnt_d = period_cnt_q + PW'(1);
               end else if (bit_cnt_q != '0) begin
                  shreg_d      = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                  bit_cnt_d    = bit_cnt_q - BW'(1);
                  period_cnt_d = '0;
               end else if (accept) begin
                  // Back-to-back streaming: next MSB follows the LSB directly
                  shreg_d      = bus.Parallel_Data_In;
                  bit_cnt_d    = BIT_FIRST;
                  period_cnt_d = '0;
               end else if (GAP_CYCLES > 0) begin
                  state_d      = S_GAP;
                  gap_cnt_d    = '0;
               end else begin
                  state_d      = S_IDLE;
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_d   = S_IDLE;
               end else begin
                  gap_cnt_d = gap_cnt_q + GW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_q      <= S_IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         period_cnt_q <= '0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         period_cnt_q <= period_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign bus.Data_Ready_Out        = ready;
   assign bus.Serial_Data_Out       = (state_q == S_SHIFT) && shreg_q[DATA_WIDTH-1];
   assign bus.Shift_Data_Signal_Out = strobe;
   assign bus.Word_Done_Out         = last_bit;
   assign bus.Busy_Out              = (state_q != S_IDLE);
endmodule
`default_nettype wire
